// File: rtl/mac_seq_ctrl_if.sv
// mac_seq_ctrl_if: job data stream, MAC command and MAC response handshakes
interface mac_seq_ctrl_if;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        m_cmd_valid;
    logic        m_cmd_ready;
    logic [9:0]  m_cmd_function_id;
    logic [31:0] m_cmd_inputs_0;
    logic [31:0] m_cmd_inputs_1;
    logic        m_rsp_valid;
    logic        m_rsp_ready;
    logic [31:0] m_rsp_outputs_0;
    modport master (
        input  s_valid, s_data, m_cmd_ready, m_rsp_valid, m_rsp_outputs_0,
        output s_ready, m_cmd_valid, m_cmd_function_id, m_cmd_inputs_0, m_cmd_inputs_1, m_rsp_ready
    );
    modport slave (
        output s_valid, s_data, m_cmd_ready, m_rsp_valid, m_rsp_outputs_0,
        input  s_ready, m_cmd_valid, m_cmd_function_id, m_cmd_inputs_0, m_cmd_inputs_1, m_rsp_ready
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences filter LOAD and MAC jobs into one-at-a-time MAC unit commands
module mac_seq_ctrl #(
    parameter int SET_DEPTH = 324,
    parameter int S_DEPTH   = 108
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          op,
    input  logic [2:0]    set_sel,
    input  logic [8:0]    base,
    input  logic [8:0]    len,
    mac_seq_ctrl_if.master bus,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [31:0]   result
);
    typedef enum logic [2:0] {IDLE, CLR, ISSUE, WAIT_RSP, FIN} state_t;
    state_t      state_q, state_d;
    logic        op_q, clr_q, clr_d, err_q, err_d, bad, ld;
    logic [2:0]  set_q;
    logic [8:0]  base_q, len_q, i_q, i_d, i_inc, i_nxt;
    logic [9:0]  idx, limit;
    logic [6:0]  fn;
    logic [31:0] result_q, result_d;
    assign limit = set_sel == 3'd0 ? 10'(S_DEPTH) : 10'(SET_DEPTH);
    assign bad   = len == 9'd0 || set_sel > 3'd4 || {1'b0, base} + {1'b0, len} > limit;
    assign ld    = state_q == IDLE && start && !bad;
    // 10-bit index so base+len == depth never wraps
    assign idx   = {1'b0, base_q} + {1'b0, i_q};
    assign i_inc = i_q + 9'd1;
    assign i_nxt = clr_q ? i_q : i_inc;
    assign fn    = op_q ? (set_q == 3'd0 ? 7'd0 : {4'd0, set_q} + 7'd6)
                        : (set_q == 3'd0 ? 7'd2 : {4'd0, set_q} + 7'd2);
    always_comb begin
        state_d                = state_q;
        i_d                    = i_q;
        clr_d                  = clr_q;
        result_d               = result_q;
        err_d                  = 1'b0;
        bus.s_ready            = 1'b0;
        bus.m_cmd_valid        = 1'b0;
        bus.m_cmd_function_id  = 10'd0;
        bus.m_cmd_inputs_0     = 32'd0;
        bus.m_cmd_inputs_1     = 32'd0;
        bus.m_rsp_ready        = 1'b0;
        case (state_q)
            IDLE: begin
                err_d = start && bad;
                if (ld) begin
                    state_d = op ? CLR : ISSUE;
                    i_d     = 9'd0;
                end
            end
            CLR: begin
                bus.m_cmd_valid       = 1'b1;
                bus.m_cmd_function_id = {7'd1, 3'b000};
                clr_d                 = 1'b1;
                state_d               = bus.m_cmd_ready ? WAIT_RSP : CLR;
            end
            ISSUE: begin
                bus.m_cmd_valid       = bus.s_valid;
                bus.s_ready           = bus.m_cmd_ready;
                bus.m_cmd_function_id = {fn, 3'b000};
                bus.m_cmd_inputs_0    = op_q ? bus.s_data : {22'd0, idx};
                bus.m_cmd_inputs_1    = op_q ? {22'd0, idx} : bus.s_data;
                if (bus.s_valid && bus.m_cmd_ready) begin
                    state_d = WAIT_RSP;
                    clr_d   = 1'b0;
                end
            end
            WAIT_RSP: begin
                bus.m_rsp_ready = 1'b1;
                if (bus.m_rsp_valid) begin
                    i_d      = i_nxt;
                    state_d  = i_nxt < len_q ? ISSUE : FIN;
                    result_d = !clr_q && op_q && i_inc >= len_q ? bus.m_rsp_outputs_0 : result_q;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            op_q     <= 1'b0;
            set_q    <= 3'd0;
            base_q   <= 9'd0;
            len_q    <= 9'd0;
            i_q      <= 9'd0;
            clr_q    <= 1'b0;
            err_q    <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            clr_q    <= clr_d;
            err_q    <= err_d;
            result_q <= result_d;
            if (ld) begin
                op_q   <= op;
                set_q  <= set_sel;
                base_q <= base;
                len_q  <= len;
            end
        end
    end
    assign busy   = state_q != IDLE;
    assign done   = state_q == FIN;
    assign err    = err_q;
    assign result = result_q;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: directed jobs against a MAC-unit model; commands checked by a scoreboard monitor
module tb_mac_seq_ctrl;
    logic        clk, reset, start, op, busy, done, err;
    logic [2:0]  set_sel;
    logic [8:0]  base, len;
    logic [31:0] result;
    int          n_cmp = 0, n_fail = 0, rsp_delay = 0;
    logic [73:0] exp_q[$];
    logic [31:0] wq[$];
    logic        out_q = 1'b0;
    logic [31:0] filt [0:4][0:511];
    int          acc = 0;

    mac_seq_ctrl_if bus();
    mac_seq_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .set_sel(set_sel),
        .base(base), .len(len), .bus(bus), .busy(busy), .done(done), .err(err), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [95:0] a, input logic [95:0] e);
        n_cmp++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    // scoreboard monitor: every fired command is popped against the expected queue
    initial forever begin
        @(negedge clk);
        if (!reset) out_q = 1'b0;
        else begin
            if (bus.m_cmd_valid && bus.m_cmd_ready) begin
                chk("one outstanding", out_q, 1'b0);
                if (exp_q.size() == 0) chk("unexpected cmd", {bus.m_cmd_function_id, bus.m_cmd_inputs_0, bus.m_cmd_inputs_1}, 74'd0);
                else chk("cmd", {bus.m_cmd_function_id, bus.m_cmd_inputs_0, bus.m_cmd_inputs_1}, exp_q.pop_front());
                out_q = 1'b1;
            end
            if (bus.m_rsp_valid && bus.m_rsp_ready) out_q = 1'b0;
        end
    end

    // MAC unit model: CLR zeroes acc, LOAD writes filters, MAC adds (x+128)*w per int8 lane
    initial begin
        logic        cf, rf, pend;
        logic [9:0]  c_fid;
        logic [31:0] c_in0, c_in1, rv, f;
        int          fid7, wait_n, nl;
        pend = 1'b0; wait_n = 0; rv = 0;
        for (int s = 0; s < 5; s++) for (int a = 0; a < 512; a++) filt[s][a] = 32'd0;
        forever begin
            @(negedge clk);
            cf = bus.m_cmd_valid && bus.m_cmd_ready;
            rf = bus.m_rsp_valid && bus.m_rsp_ready;
            c_fid = bus.m_cmd_function_id; c_in0 = bus.m_cmd_inputs_0; c_in1 = bus.m_cmd_inputs_1;
            @(posedge clk); #1;
            if (!reset) begin
                bus.m_rsp_valid = 1'b0;
                pend = 1'b0;
            end else begin
                if (rf) bus.m_rsp_valid = 1'b0;
                if (cf) begin
                    fid7 = int'(c_fid[9:3]);
                    rv = 32'd0;
                    if (fid7 == 1) acc = 0;
                    else if (fid7 >= 2 && fid7 <= 6) filt[fid7-2][c_in0[8:0]] = c_in1;
                    else if (fid7 == 0 || (fid7 >= 7 && fid7 <= 10)) begin
                        f  = fid7 == 0 ? filt[0][c_in1[8:0]] : filt[fid7-6][c_in1[8:0]];
                        nl = fid7 == 0 ? 1 : 4;
                        for (int l = 0; l < nl; l++)
                            acc += (int'($signed(c_in0[8*l +: 8])) + 128) * int'($signed(f[8*l +: 8]));
                        rv = acc;
                    end
                    pend = 1'b1;
                    wait_n = rsp_delay;
                end
                if (pend) begin
                    if (wait_n == 0) begin
                        bus.m_rsp_valid = 1'b1;
                        bus.m_rsp_outputs_0 = rv;
                        pend = 1'b0;
                    end else wait_n--;
                end
            end
        end
    end

    task automatic kick(input logic o, input logic [2:0] s, input logic [8:0] b, input logic [8:0] l);
        @(posedge clk); #1;
        start = 1'b1; op = o; set_sel = s; base = b; len = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input logic [31:0] w, input int gap);
        int k = 0;
        bus.s_valid = 1'b1; bus.s_data = w;
        @(negedge clk);
        while (!(bus.s_valid && bus.s_ready) && k < 300) begin @(negedge clk); k++; end
        chk("feed accepted", bus.s_valid && bus.s_ready, 1'b1);
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic wait_done(input string nm, input logic [31:0] e);
        int k = 0;
        @(negedge clk);
        while (!done && k < 300) begin @(negedge clk); k++; end
        chk({nm, " done"}, done, 1'b1);
        chk({nm, " result"}, result, e);
        @(negedge clk);
        chk({nm, " done one cycle"}, done, 1'b0);
        chk({nm, " idle"}, busy, 1'b0);
        chk({nm, " cmds drained"}, exp_q.size(), 0);
    endtask

    task automatic job(input string nm, input logic o, input logic [2:0] s, input logic [8:0] b,
                       input int gap, input logic [31:0] e);
        int n = wq.size();
        kick(o, s, b, 9'(n));
        for (int j = 0; j < n; j++) feed(wq[j], j < n - 1 ? gap : 0);
        wq.delete();
        wait_done(nm, e);
    endtask

    task automatic bad_start(input string nm, input logic [2:0] s, input logic [8:0] b, input logic [8:0] l);
        kick(1'b1, s, b, l);
        @(negedge clk);
        chk({nm, " err"}, err, 1'b1);
        chk({nm, " busy"}, busy, 1'b0);
        @(negedge clk);
        chk({nm, " err pulse"}, err, 1'b0);
        chk({nm, " still idle"}, busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; start = 1'b0; op = 1'b0; set_sel = 3'd0; base = 9'd0; len = 9'd0;
        bus.s_valid = 1'b0; bus.s_data = 32'd0; bus.m_cmd_ready = 1'b1;
        bus.m_rsp_valid = 1'b0; bus.m_rsp_outputs_0 = 32'd0;
        #12;
        chk("reset outputs", {busy, done, err, result, bus.m_cmd_valid, bus.s_ready, bus.m_rsp_ready}, 38'd0);
        @(posedge clk); #1; reset = 1'b1;

        // LOAD set 1: two filter words, result untouched
        exp_q.push_back({10'd24, 32'd0, 32'h01010101});
        exp_q.push_back({10'd24, 32'd1, 32'h02020202});
        wq = '{32'h01010101, 32'h02020202};
        job("load set1", 1'b0, 3'd1, 9'd0, 0, 32'd0);

        // MAC set 1: clear then one MAC, 4 lanes of 1*1
        exp_q.push_back({10'd8, 32'd0, 32'd0});
        exp_q.push_back({10'd56, 32'h81818181, 32'd0});
        wq = '{32'h81818181};
        job("mac set1", 1'b1, 3'd1, 9'd0, 0, 32'd4);

        // backpressure on the command port holds payload and index
        exp_q.push_back({10'd32, 32'd5, 32'hA5A50001});
        exp_q.push_back({10'd32, 32'd6, 32'hA5A50002});
        bus.m_cmd_ready = 1'b0;
        kick(1'b0, 3'd2, 9'd5, 9'd2);
        bus.s_valid = 1'b1; bus.s_data = 32'hA5A50001;
        repeat (5) begin
            @(negedge clk);
            chk("stall payload", {bus.m_cmd_valid, bus.s_ready, bus.m_cmd_function_id, bus.m_cmd_inputs_0, bus.m_cmd_inputs_1},
                {1'b1, 1'b0, 10'd32, 32'd5, 32'hA5A50001});
        end
        @(posedge clk); #1; bus.m_cmd_ready = 1'b1;
        feed(32'hA5A50001, 0);
        feed(32'hA5A50002, 0);
        wait_done("stall load", 32'd4);

        // set 0 boundary: base 107 len 1 legal
        exp_q.push_back({10'd16, 32'd107, 32'd3});
        wq = '{32'd3};
        job("load set0 edge", 1'b0, 3'd0, 9'd107, 0, 32'd4);
        exp_q.push_back({10'd8, 32'd0, 32'd0});
        exp_q.push_back({10'd0, 32'h00000085, 32'd107});
        wq = '{32'h00000085};
        job("mac set0 edge", 1'b1, 3'd0, 9'd107, 0, 32'd15);

        // set 4 boundary: base+len == SET_DEPTH legal
        exp_q.push_back({10'd48, 32'd323, 32'h11});
        wq = '{32'h11};
        job("load set4 edge", 1'b0, 3'd4, 9'd323, 0, 32'd15);

        bad_start("set0 overrun", 3'd0, 9'd107, 9'd2);
        bad_start("set1 overrun", 3'd1, 9'd300, 9'd25);
        bad_start("len zero", 3'd1, 9'd0, 9'd0);
        bad_start("set illegal", 3'd5, 9'd0, 9'd1);

        // slow responses and gapped stream: 4*1*1 + 4*2*2
        rsp_delay = 3;
        exp_q.push_back({10'd8, 32'd0, 32'd0});
        exp_q.push_back({10'd56, 32'h81818181, 32'd0});
        exp_q.push_back({10'd56, 32'h82828282, 32'd1});
        wq = '{32'h81818181, 32'h82828282};
        job("mac slow", 1'b1, 3'd1, 9'd0, 2, 32'd20);

        // reset while waiting for a response
        rsp_delay = 5;
        exp_q.push_back({10'd40, 32'd10, 32'hDEADBEEF});
        kick(1'b0, 3'd3, 9'd10, 9'd1);
        feed(32'hDEADBEEF, 0);
        @(negedge clk);
        chk("in wait_rsp", {busy, bus.m_rsp_ready}, 2'b11);
        reset = 1'b0;
        #1;
        chk("async reset outputs", {busy, done, err, result, bus.m_cmd_valid, bus.s_ready, bus.m_rsp_ready}, 38'd0);
        repeat (2) @(posedge clk);
        #1; reset = 1'b1;
        repeat (8) @(negedge clk);
        chk("no stale activity", {busy, done, bus.m_rsp_ready}, 3'd0);
        rsp_delay = 0;
        exp_q.push_back({10'd8, 32'd0, 32'd0});
        exp_q.push_back({10'd56, 32'h81818181, 32'd0});
        wq = '{32'h81818181};
        job("mac after reset", 1'b1, 3'd1, 9'd0, 0, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
